// File: rtl/adc_moving_average_if.sv
// Sample/average stream between the ADC reader, the boxcar filter and its consumer.
// slave is the filter's view: it takes raw samples in and drives the averages out.
interface adc_moving_average_if;
  logic       axiiv;
  logic [9:0] axiid;
  logic       axiov;
  logic [9:0] axiod;
  logic       filled;

  modport master (output axiiv, axiid, input axiov, axiod, filled);
  modport slave  (input axiiv, axiid, output axiov, axiod, filled);
endinterface

// File: rtl/adc_moving_average.sv
// Streaming boxcar filter: mean of the last 2^LOG2_WINDOW 10-bit ADC samples,
// one output pulse per accepted sample, one cycle of latency.
module adc_moving_average #(
  parameter int LOG2_WINDOW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  adc_moving_average_if.slave  bus
);

  localparam int W     = 1 << LOG2_WINDOW;
  localparam int SUM_W = 10 + LOG2_WINDOW;

  logic [9:0]             buffer [W];
  logic [LOG2_WINDOW-1:0] wr_ptr;
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       next_sum;
  logic [LOG2_WINDOW:0]   fill_cnt;

  // Add the new sample and drop the one it overwrites; the sum is sized for W*1023.
  assign next_sum   = sum + SUM_W'(bus.axiid) - SUM_W'(buffer[wr_ptr]);
  assign bus.filled = (fill_cnt == (LOG2_WINDOW + 1)'(W));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // NOTE: the history must be zeroed, otherwise stale entries get subtracted from a fresh window.
      for (int i = 0; i < W; i++) buffer[i] <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
    end else if (bus.axiiv) begin
      buffer[wr_ptr] <= bus.axiid;
      wr_ptr         <= wr_ptr + 1'b1;
      sum            <= next_sum;
      bus.axiod      <= next_sum[SUM_W-1:LOG2_WINDOW];
      bus.axiov      <= 1'b1;
      if (!bus.filled) fill_cnt <= fill_cnt + 1'b1;
    end else begin
      bus.axiov <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_moving_average.sv
// Bench for adc_moving_average: directed scenarios plus random traffic, checked
// against a queue-based model of the last W samples.
module tb_adc_moving_average;

  localparam int LOG2 = 4;
  localparam int W    = 1 << LOG2;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  adc_moving_average_if bus ();

  adc_moving_average #(.LOG2_WINDOW(LOG2)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         hist[$];
  int         accepted;
  logic       exp_v;
  logic [9:0] exp_d;
  logic       exp_f;

  // Apply inputs for one cycle, then advance the model to what the outputs should show.
  task automatic step(input logic v, input logic [9:0] d, input logic c, input logic r);
    int s;
    bus.axiiv = v;
    bus.axiid = d;
    clear     = c;
    rst       = r;
    @(posedge clk);
    @(negedge clk);
    if (r || c) begin
      hist.delete();
      accepted = 0;
      exp_v = 1'b0;
      exp_d = '0;
    end else if (v) begin
      hist.push_back(int'(d));
      if (hist.size() > W) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      exp_d = 10'(s / W);
      exp_v = 1'b1;
      if (accepted < W) accepted++;
    end else begin
      exp_v = 1'b0;
    end
    exp_f = (accepted == W);
  endtask

  task automatic test_reset();
    step(1'b1, 10'd777, 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    checks++;
    if (bus.axiov !== 1'b0 || bus.axiod !== 10'd0 || bus.filled !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%0d f=%b, want v=0 d=0 f=0", bus.axiov, bus.axiod, bus.filled);
    end
    step(1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic test_warmup();
    for (int k = 1; k <= W; k++) begin
      step(1'b1, 10'd512, 1'b0, 1'b0);
      checks++;
      if (bus.axiov !== 1'b1 || bus.axiod !== 10'(32 * k) || bus.filled !== (k == W)) begin
        errors++;
        $display("FAIL warmup k=%0d: got v=%b d=%0d f=%b, want v=1 d=%0d f=%b",
                 k, bus.axiov, bus.axiod, bus.filled, 32 * k, k == W);
      end
      for (int g = 0; g < 99; g++) begin
        step(1'b0, 10'd0, 1'b0, 1'b0);
        checks++;
        if (bus.axiov !== 1'b0 || bus.axiod !== 10'(32 * k)) begin
          errors++;
          $display("FAIL warmup_idle k=%0d: got v=%b d=%0d, want v=0 d=%0d",
                   k, bus.axiov, bus.axiod, 32 * k);
        end
      end
    end
  endtask

  task automatic test_step_wrap();
    int want;
    step(1'b0, 10'd0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b1, 10'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, 10'd1023, 1'b0, 1'b0);
      want = (k <= W) ? (1023 * k) / 16 : 1023;
      checks++;
      if (bus.axiov !== 1'b1 || bus.axiod !== 10'(want) || bus.axiod !== exp_d) begin
        errors++;
        $display("FAIL step_wrap k=%0d: got v=%b d=%0d, want v=1 d=%0d", k, bus.axiov, bus.axiod, want);
      end
    end
  endtask

  task automatic test_full_scale();
    int pulses = 0;
    step(1'b0, 10'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd1023, 1'b0, 1'b0);
      if (bus.axiov === 1'b1) pulses++;
      checks++;
      if (bus.axiov !== 1'b1 || bus.axiod !== exp_d || bus.filled !== exp_f) begin
        errors++;
        $display("FAIL full_scale k=%0d: got v=%b d=%0d f=%b, want v=1 d=%0d f=%b",
                 k, bus.axiov, bus.axiod, bus.filled, exp_d, exp_f);
      end
    end
    checks++;
    if (pulses != 40 || bus.axiod !== 10'd1023 || dut.sum !== 14'd16368) begin
      errors++;
      $display("FAIL full_scale_end: got pulses=%0d d=%0d sum=%0d, want 40 1023 16368",
               pulses, bus.axiod, dut.sum);
    end
    step(1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic test_mixed();
    step(1'b0, 10'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step(1'b1, (k % 2 == 1) ? 10'd0 : 10'd1000, 1'b0, 1'b0);
      checks++;
      if (bus.axiov !== 1'b1 || bus.axiod !== exp_d || (k >= W && bus.axiod !== 10'd500)) begin
        errors++;
        $display("FAIL mixed k=%0d: got v=%b d=%0d, want v=1 d=%0d", k, bus.axiov, bus.axiod, exp_d);
      end
    end
  endtask

  task automatic test_clear_mid();
    step(1'b0, 10'd0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 10'd800, 1'b0, 1'b0);
    checks++;
    if (bus.axiod !== 10'd800 || bus.filled !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre: got d=%0d f=%b, want d=800 f=1", bus.axiod, bus.filled);
    end
    step(1'b1, 10'd100, 1'b1, 1'b0);
    checks++;
    if (bus.axiov !== 1'b0 || bus.axiod !== 10'd0 || bus.filled !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle: got v=%b d=%0d f=%b, want v=0 d=0 f=0", bus.axiov, bus.axiod, bus.filled);
    end
    step(1'b1, 10'd160, 1'b0, 1'b0);
    checks++;
    if (bus.axiov !== 1'b1 || bus.axiod !== 10'd10 || bus.filled !== 1'b0) begin
      errors++;
      $display("FAIL clear_after: got v=%b d=%0d f=%b, want v=1 d=10 f=0", bus.axiov, bus.axiod, bus.filled);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
    step(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b1);
    checks++;
    if (bus.axiov !== 1'b0 || bus.axiod !== 10'd0 || bus.filled !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b d=%0d f=%b, want v=0 d=0 f=0", bus.axiov, bus.axiod, bus.filled);
    end
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
      checks++;
      if (bus.axiov !== 1'b1 || bus.axiod !== exp_d || bus.filled !== (k >= W)) begin
        errors++;
        $display("FAIL reset_mid_burst k=%0d: got v=%b d=%0d f=%b, want v=1 d=%0d f=%b",
                 k, bus.axiov, bus.axiod, bus.filled, exp_d, k >= W);
      end
    end
  endtask

  task automatic test_random();
    logic v, c;
    for (int k = 0; k < 400; k++) begin
      v = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 59) == 0);
      step(v, 10'($urandom_range(0, 1023)), c, 1'b0);
      checks++;
      if (bus.axiov !== exp_v || bus.axiod !== exp_d || bus.filled !== exp_f) begin
        errors++;
        $display("FAIL random k=%0d: got v=%b d=%0d f=%b, want v=%b d=%0d f=%b",
                 k, bus.axiov, bus.axiod, bus.filled, exp_v, exp_d, exp_f);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = '0;
    accepted  = 0;
    exp_v     = 1'b0;
    exp_d     = '0;
    exp_f     = 1'b0;
    @(negedge clk);
    test_reset();
    test_warmup();
    test_step_wrap();
    test_full_scale();
    test_mixed();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_moving_average.md
# adc_moving_average

Streaming boxcar filter that sits directly downstream of the MCP3008 ADC reader. It consumes the 10-bit single-ended CH0 samples that the reader emits as single-cycle valid pulses. For each sample it produces the mean of the most recent 2^LOG2_WINDOW samples as a 10-bit value with a one-cycle valid pulse. This gives the rest of the design a de-noised ADC reading at the raw sample rate.

## Interface
- LOG2_WINDOW, default 4: window length W = 2^LOG2_WINDOW samples. Legal range is 1..6.
- clk  input  1: system clock; the only clock in the block.
- rst  input  1: reset, synchronous, active-high.
- clear  input  1: synchronous restart of the filter history. It has the same internal effect as rst.
- axiiv  input  1: input sample valid. Single-cycle pulse; no backpressure.
- axiid  input  10: unsigned ADC code (0..1023), sampled when axiiv=1.
- axiov  output  1: output average valid. Single-cycle pulse.
- axiod  output  10: windowed mean, floor(sum/W). Held between pulses.
- filled  output  1: high once W samples have been accepted since the last rst or clear.

## Operation
- State:
  - history buffer of W × 10-bit entries (registers), written circularly;
  - write pointer wr_ptr (LOG2_WINDOW bits);
  - running sum of 10+LOG2_WINDOW bits;
  - fill counter, saturating at W.
- Accepting a sample (axiiv=1 and clear=0):
  - next_sum = sum + axiid − buffer[wr_ptr];
  - buffer[wr_ptr] <= axiid;
  - wr_ptr <= wr_ptr+1, wrapping from W−1 to 0;
  - sum <= next_sum;
  - axiod <= next_sum >> LOG2_WINDOW (truncation, no rounding);
  - axiov <= 1;
  - fill counter increments and saturates at W.
- Warm-up: buffer entries reset to 0, so before W samples have been accepted the output is (sum of samples so far)/W, biased low. filled=0 marks this region.
- Sum width is sized exactly for W × 1023. No overflow or saturation logic is required, and the subtraction never goes negative.
- Cycles without an accepted sample: axiov <= 0. axiod, sum, buffer and wr_ptr hold their values.
- rst or clear: all buffer entries, sum, wr_ptr and the fill counter go to 0. axiov=0, axiod=0, filled=0.
- clear and axiiv in the same cycle: clear wins and the sample is dropped (no axiov). rst has priority over everything.
- The block accepts axiiv in any number of consecutive cycles, including every cycle.

## Timing
- Reset values: axiov=0, axiod=10'd0, filled=0.
- Latency: a sample presented with axiiv=1 in cycle N gives axiov=1 in cycle N+1, with axiod reflecting that sample. There is exactly one axiov pulse per accepted sample, and no pulse is merged or dropped at full input rate.
- filled rises in the same cycle as the axiov of the W-th accepted sample. It stays high until rst or clear.
- After clear in cycle N, every output equals its reset value from cycle N+1. The first sample accepted from cycle N+1 onward starts a fresh window.
- Register-only datapath: one adder/subtractor in the next_sum path, and no multi-cycle paths.

## Test plan
- **Warm-up ramp** (W=16): 16 samples of 512, one every 100 cycles.
  - k-th axiov (k=1..16) must carry axiod=32k.
  - filled goes high with the 16th pulse, where axiod=512.
- **Step and wrap**: after 16×0, feed 24×1023.
  - Outputs are floor(1023k/16) for k=1..16, then 1023 for the rest.
  - This checks wr_ptr wrap and removal of the oldest sample.
- **Full scale**: 40 back-to-back samples of 1023 (axiiv every cycle).
  - 40 axiov pulses in 40 consecutive cycles.
  - Final sum is 16368 and axiod=1023, with no overflow.
- **Mixed window**: alternating 0 and 1000 for 32 samples.
  - Once filled, every output is 500.
- **Clear mid-stream**: after 20×800, assert clear together with an axiiv carrying 100.
  - No axiov that cycle; next cycle filled=0 and axiod=0.
  - Then 1 sample of 160 must give axiod=10.
- **Reset mid-operation**: assert rst for one cycle during a back-to-back burst.
  - Outputs take their reset values in the following cycle.
  - Post-reset results match those of a freshly reset block.
